// File: rtl/grande_risco5_pkg.sv
// Shared constants for the Grande_Risco5 memory arbiter: FSM state
// encoding and the grant identifiers used for round-robin bookkeeping.
package grande_risco5_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and
// the data port of the core. Each access walks IDLE -> ACCESS -> RESP, so
// a zero-wait memory gives one access every three cycles. All outputs are
// registered; the mem_* outputs double as the latched operation/address.
//
// Handshake: a requester holds its request (and address/data stable) until
// its one-cycle response pulse. Requests are only sampled in IDLE; anything
// that changes during ACCESS or RESP is ignored. The memory side keeps the
// strobe, address and write data steady until mem_response is seen high on
// a rising edge; the strobe drops at that same edge.
module memory_arbiter
    import grande_risco5_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instruction_request,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [DATA_WIDTH-1:0] instruction_data,
    output logic                  instruction_response,
    input  logic                  data_memory_read,
    input  logic                  data_memory_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  data_memory_response,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_response,
    output logic [1:0]            o_dbg_state
);

    logic [1:0] r_state;
    logic       r_last_grant;
    logic       r_grant;

    logic       w_data_req;
    logic       w_any_req;
    logic       w_grant;

    assign w_data_req  = data_memory_read | data_memory_write;
    assign w_any_req   = w_data_req | instruction_request;
    assign o_dbg_state = r_state;

    // Pick the winner among the requests visible this cycle.
    always_comb begin
        w_grant = GRANT_INSTR;
        if (w_data_req && !instruction_request) begin
            w_grant = GRANT_DATA;
        end else if (w_data_req && instruction_request) begin
            if (ROUND_ROBIN != 0) begin
                w_grant = (r_last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
            end else begin
                w_grant = GRANT_DATA;
            end
        end
    end

    // Arbiter FSM plus all registered outputs; reset drops strobes at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state              <= IDLE;
            r_last_grant         <= GRANT_INSTR;
            r_grant              <= GRANT_INSTR;
            instruction_data     <= '0;
            instruction_response <= 1'b0;
            read_data            <= '0;
            data_memory_response <= 1'b0;
            mem_read             <= 1'b0;
            mem_write            <= 1'b0;
            mem_address          <= '0;
            mem_write_data       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ACCESS;
                        if (w_grant == GRANT_DATA) begin
                            mem_address    <= data_address;
                            mem_write_data <= write_data;
                            // Read and write both set is treated as a write.
                            mem_write      <= data_memory_write;
                            mem_read       <= ~data_memory_write;
                        end else begin
                            mem_address    <= instruction_address;
                            mem_write_data <= '0;
                            mem_write      <= 1'b0;
                            mem_read       <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_response) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_state   <= RESP;
                        if (r_grant == GRANT_DATA) begin
                            data_memory_response <= 1'b1;
                            // Stores leave read_data untouched.
                            if (mem_read) begin
                                read_data <= mem_read_data;
                            end
                        end else begin
                            instruction_response <= 1'b1;
                            instruction_data     <= mem_read_data;
                        end
                    end
                end
                RESP: begin
                    instruction_response <= 1'b0;
                    data_memory_response <= 1'b0;
                    r_state              <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a behavioural shared memory with programmable
// wait states, directed transactions, and a response monitor that pops
// expected words from per-port queues.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instruction_request = 1'b0;
    logic [31:0] instruction_address = '0;
    logic [31:0] instruction_data;
    logic        instruction_response;
    logic        data_memory_read = 1'b0;
    logic        data_memory_write = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        data_memory_response;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic [1:0]  dbg_state;

    // second instance: fixed data priority, trivial zero-wait memory
    logic        reset2 = 1'b0;
    logic        i2_req = 1'b0;
    logic [31:0] i2_addr = '0;
    logic [31:0] i2_data;
    logic        i2_resp;
    logic        d2_rd = 1'b0;
    logic        d2_wr = 1'b0;
    logic [31:0] d2_addr = '0;
    logic [31:0] d2_wdata = '0;
    logic [31:0] d2_rdata;
    logic        d2_resp;
    logic        m2_read;
    logic        m2_write;
    logic [31:0] m2_addr;
    logic [31:0] m2_wdata;
    logic [31:0] m2_rdata;
    logic        m2_resp;
    logic [1:0]  dbg_state2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wait_states = 0;
    int wcnt = 0;

    logic [31:0] mem_arr [0:255];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    int          log_port[$];
    int          log_cyc[$];

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset),
        .instruction_request(instruction_request), .instruction_address(instruction_address),
        .instruction_data(instruction_data), .instruction_response(instruction_response),
        .data_memory_read(data_memory_read), .data_memory_write(data_memory_write),
        .data_address(data_address), .write_data(write_data),
        .read_data(read_data), .data_memory_response(data_memory_response),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_response(mem_response), .o_dbg_state(dbg_state)
    );

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .reset(reset2),
        .instruction_request(i2_req), .instruction_address(i2_addr),
        .instruction_data(i2_data), .instruction_response(i2_resp),
        .data_memory_read(d2_rd), .data_memory_write(d2_wr),
        .data_address(d2_addr), .write_data(d2_wdata),
        .read_data(d2_rdata), .data_memory_response(d2_resp),
        .mem_read(m2_read), .mem_write(m2_write), .mem_address(m2_addr),
        .mem_write_data(m2_wdata), .mem_read_data(m2_rdata),
        .mem_response(m2_resp), .o_dbg_state(dbg_state2)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // shared memory model with wait states
    assign mem_response  = (mem_read | mem_write) && (wcnt == wait_states);
    assign mem_read_data = mem_arr[mem_address[9:2]];
    always @(posedge clk) begin
        if (!(mem_read | mem_write) || mem_response) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (mem_write && mem_response) mem_arr[mem_address[9:2]] <= mem_write_data;
    end

    assign m2_resp  = m2_read | m2_write;
    assign m2_rdata = {m2_addr[15:0], 16'h5A5A};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (instruction_response || data_memory_response)
                check("one_resp_at_a_time", 32'(instruction_response & data_memory_response), 0);
            if (mem_read || mem_write)
                check("strobe_exclusive", 32'(mem_read & mem_write), 0);
            if (instruction_response) begin
                log_port.push_back(0);
                log_cyc.push_back(cyc);
                if (exp_i_q.size() == 0) check("unexpected_iresp", 1, 0);
                else check("instruction_data", instruction_data, exp_i_q.pop_front());
            end
            if (data_memory_response) begin
                log_port.push_back(1);
                log_cyc.push_back(cyc);
                if (exp_d_q.size() == 0) check("unexpected_dresp", 1, 0);
                else check("read_data", read_data, exp_d_q.pop_front());
            end
        end
    end

    // driver: one fetch, returns with the arbiter back in IDLE
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_lat, input int exp_strobes);
        int n = 0;
        int rd = 0;
        bit stable = 1'b1;
        bit done = 1'b0;
        exp_i_q.push_back(exp);
        instruction_address = addr;
        instruction_request = 1'b1;
        while (!done && n < 60) begin
            @(negedge clk); #1;
            n++;
            if (mem_read) begin
                rd++;
                if (mem_address !== addr) stable = 1'b0;
            end
            if (instruction_response) done = 1'b1;
        end
        instruction_request = 1'b0;
        if (!done) check("fetch_timeout", 0, 1);
        else begin
            check("fetch_latency", n, exp_lat);
            check("fetch_read_cycles", rd, exp_strobes);
            check("fetch_addr_stable", 32'(stable), 1);
        end
        @(negedge clk); #1;
    endtask

    // driver: one data access, returns with the arbiter back in IDLE
    task automatic data_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rd);
        int n = 0;
        int rc = 0;
        int wc = 0;
        bit done = 1'b0;
        exp_d_q.push_back(exp_rd);
        data_address = addr;
        write_data = wdata;
        data_memory_write = wr;
        data_memory_read = ~wr;
        while (!done && n < 60) begin
            @(negedge clk); #1;
            n++;
            if (mem_read) rc++;
            if (mem_write) begin
                wc++;
                check("mem_write_data", mem_write_data, wdata);
                check("mem_write_addr", mem_address, addr);
            end
            if (data_memory_response) done = 1'b1;
        end
        data_memory_write = 1'b0;
        data_memory_read = 1'b0;
        if (!done) check("data_timeout", 0, 1);
        else begin
            check("data_latency", n, 2);
            check("data_write_cycles", wc, wr ? 1 : 0);
            check("data_read_cycles", rc, wr ? 0 : 1);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        int dcnt;
        int icnt;
        bit got;
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        mem_arr[0] = 32'h0000_0013;
        mem_arr[1] = 32'h0010_0093;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_instruction_data", instruction_data, 0);
        check("rst_instruction_response", 32'(instruction_response), 0);
        check("rst_read_data", read_data, 0);
        check("rst_data_memory_response", 32'(data_memory_response), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        check("rst_state", 32'(dbg_state), 0);
        reset = 1'b1;
        reset2 = 1'b1;
        @(negedge clk); #1;

        // fetch only, zero-wait
        fetch(32'h0, 32'h0000_0013, 2, 1);

        // store then load
        data_access(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        data_access(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);

        // wait states: 4 extra cycles before mem_response
        wait_states = 4;
        fetch(32'h4, 32'h0010_0093, 6, 5);
        wait_states = 0;

        // round-robin contention straight out of reset
        reset = 1'b0;
        log_port.delete();
        log_cyc.delete();
        instruction_address = 32'h0;
        instruction_request = 1'b1;
        data_address = 32'h100;
        data_memory_read = 1'b1;
        exp_d_q.push_back(32'hDEAD_BEEF);
        exp_i_q.push_back(32'h0000_0013);
        exp_d_q.push_back(32'hDEAD_BEEF);
        exp_i_q.push_back(32'h0000_0013);
        @(negedge clk); #1;
        reset = 1'b1;
        n = 0;
        while (log_port.size() < 4 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        instruction_request = 1'b0;
        data_memory_read = 1'b0;
        @(negedge clk); #1;
        if (log_port.size() < 4) check("rr_timeout", 32'(log_port.size()), 4);
        else begin
            for (int i = 0; i < 4; i++) check("rr_order", log_port[i], (i % 2 == 0) ? 1 : 0);
            for (int i = 1; i < 4; i++) check("rr_spacing", log_cyc[i] - log_cyc[i-1], 3);
        end

        // reset in the second ACCESS cycle of a stalled fetch
        wait_states = 4;
        instruction_address = 32'h4;
        instruction_request = 1'b1;
        @(negedge clk); #1;
        check("abort_first_access", 32'(mem_read), 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_mem_read_async", 32'(mem_read), 0);
        check("abort_state", 32'(dbg_state), 0);
        instruction_request = 1'b0;
        got = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            if (instruction_response) got = 1'b1;
        end
        check("abort_no_response", 32'(got), 0);
        reset = 1'b1;
        wait_states = 0;
        @(negedge clk); #1;
        fetch(32'h4, 32'h0010_0093, 2, 1);

        // fixed data priority on the second instance
        i2_addr = 32'h8;
        i2_req = 1'b1;
        d2_addr = 32'h200;
        d2_rd = 1'b1;
        dcnt = 0;
        icnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (d2_resp) begin
                dcnt++;
                check("fixed_read_data", d2_rdata, 32'h0200_5A5A);
            end
            if (i2_resp) icnt++;
        end
        check("fixed_data_count", dcnt, 4);
        check("fixed_instr_starved", icnt, 0);
        d2_rd = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk); #1;
            if (i2_resp) begin
                got = 1'b1;
                check("fixed_instr_data", i2_data, 32'h0008_5A5A);
            end
        end
        check("fixed_instr_served", 32'(got), 1);
        i2_req = 1'b0;
        repeat (2) @(negedge clk);

        check("exp_i_q_drained", 32'(exp_i_q.size()), 0);
        check("exp_d_q_drained", 32'(exp_d_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch port and data port.
- Sits between Grande_Risco5 and a unified Memory instance, so the core runs from a single memory image instead of split instruction/data memories.
- Produces the per-port response pulses that the core already consumes: instruction_response and data_memory_response.
- Sequences each access through a 3-state FSM and arbitrates simultaneous requests round-robin, or with fixed data priority.

Parameters:
- ADDR_WIDTH, 32: address width on all ports.
- DATA_WIDTH, 32: data width on all ports.
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = data port always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- instruction_request  in  1  fetch request; held until instruction_response.
- instruction_address  in  ADDR_WIDTH  fetch address; stable while requested.
- instruction_data  out  DATA_WIDTH  fetched word; valid when instruction_response=1.
- instruction_response  out  1  one-cycle completion pulse.
- data_memory_read  in  1  data read request.
- data_memory_write  in  1  data write request; both read and write set = write.
- data_address  in  ADDR_WIDTH  data address.
- write_data  in  DATA_WIDTH  store data.
- read_data  out  DATA_WIDTH  load data; valid when data_memory_response=1.
- data_memory_response  out  1  one-cycle completion pulse.
- mem_read  out  1  read strobe to shared memory.
- mem_write  out  1  write strobe to shared memory.
- mem_address  out  ADDR_WIDTH  shared memory address.
- mem_write_data  out  DATA_WIDTH  shared memory write data.
- mem_read_data  in  DATA_WIDTH  shared memory read data; valid with mem_response.
- mem_response  in  1  memory completion; may arrive in the first ACCESS cycle or later.

Behaviour:
- All outputs are registered.
- While reset=0, every output is 0, state=IDLE, last_grant=INSTR (data wins the first tie).
- State IDLE:
  - Sample requests. data_req = data_memory_read | data_memory_write.
  - Only one requester active: grant it.
  - Both active and ROUND_ROBIN=1: grant the port not in last_grant.
  - Both active and ROUND_ROBIN=0: grant data.
  - On grant: latch grantee, address, write data and operation; drive mem_* next cycle; go to ACCESS; update last_grant.
- State ACCESS:
  - Hold mem_read or mem_write plus address and write data steady until mem_response=1.
  - On mem_response:
    - Deassert the strobes at the next edge.
    - Reads: latch mem_read_data into the grantee's data output.
    - Go to RESP.
  - No timeout: a stalled memory holds ACCESS indefinitely.
- State RESP:
  - Grantee's response=1 for exactly one cycle; its data output is valid.
  - Requests are not sampled in RESP. The requester has one cycle to drop or replace its request.
  - Return to IDLE.
- Write completion: data_memory_response pulses; read_data holds its previous value.
- Latency with a zero-wait memory (mem_response in the first ACCESS cycle): request seen in cycle 0, mem strobe in cycle 1, response in cycle 2.
- Throughput: one access per 3 cycles minimum.
- instruction_data and read_data hold their last value between responses; they are not cleared.
- Never both responses in the same cycle. Never mem_read and mem_write together.
- A request dropped before grant is simply not serviced.
- Request changes during ACCESS or RESP are ignored; the latched values are used.
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronously), the transaction is abandoned, no response is issued.
- Addresses are passed through unchanged; there is no address decode or alignment check.

Decomposition:
- Shared package (grande_risco5_pkg):
  - Arbiter state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Grant ids: GRANT_INSTR=1'b0, GRANT_DATA=1'b1.
- No sub-module: the FSM and latches are small enough to live in one module.

Test Plan:
- Fetch only, zero-wait memory, word 0x00000013 at 0x0 → mem_read high in cycle 1 with mem_address=0x0; instruction_response pulses in cycle 2 with instruction_data=0x00000013; data port silent.
- Store then load: write 0xDEADBEEF to 0x100, then read 0x100 → mem_write once with mem_write_data=0xDEADBEEF; data_memory_response pulses twice; read_data=0xDEADBEEF on the second pulse.
- Contention, ROUND_ROBIN=1, both ports requesting continuously out of reset → grant order D,I,D,I; responses alternate every 3 cycles; never both in one cycle.
- Contention, ROUND_ROBIN=0 → data served each arbitration; fetch served only in cycles where the data request is low.
- Wait states: memory delays mem_response by 4 cycles → mem_read held 5 cycles with a stable address; a single response pulse follows.
- Reset mid-ACCESS: reset=0 in the second ACCESS cycle → mem_read=0 with no clock edge needed; no response pulse; after reset=1 a fresh fetch completes normally.
